// File: rtl/loop_term_monitor_if.sv
// loop_term_monitor_if: result bus and valid/ready handshake between the loop monitor and its checker.
interface loop_term_monitor_if #(parameter int W = 13, CNT_W = 16);
   logic res_valid, res_ready, viol;
   logic [W-1:0] res_i, res_j, res_k, res_n;
   logic [CNT_W-1:0] iter_cnt;
   logic [1:0] exit_cause;
   modport master(output res_valid, res_i, res_j, res_k, res_n, iter_cnt, exit_cause, viol, input res_ready);
   modport slave(input res_valid, res_i, res_j, res_k, res_n, iter_cnt, exit_cause, viol, output res_ready);
endinterface

// File: rtl/loop_term_monitor.sv
// loop_term_monitor: detects loop exit, latches final counters and checks the invariant.
// Defining LOOP_MON_STICKY_VIOL_EN keeps viol set across runs until reset.
module loop_term_monitor #(
   parameter int W = 13, J_LIMIT = 4855, CNT_W = 16, TIMEOUT = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic [W-1:0] i_in,
   input  logic [W-1:0] j_in,
   input  logic [W-1:0] k_in,
   input  logic [W-1:0] n_in,
   output logic busy,
   loop_term_monitor_if.master res
);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, EVAL = 2'd2, HOLD = 2'd3;
   logic [1:0] state;
   logic [W-1:0] i_prev;
   logic [CNT_W-1:0] timer;
   logic e_i, e_j, timed_out, go, new_viol;
   logic [W:0] lhs;
   logic [W+1:0] rhs;
   always_comb begin
      e_i = i_in > n_in;
      e_j = j_in > W'(J_LIMIT);
      timed_out = timer == CNT_W'(TIMEOUT - 1);
      go = start && (state == IDLE || (state == HOLD && res.res_ready));
      lhs = {res.res_n, 1'b0};
      rhs = (W+2)'(res.res_k) + (W+2)'(res.res_j) + (W+2)'(res.res_i);
      new_viol = (res.res_i > res.res_n) && ((W+2)'(lhs) >= rhs);
   end
   assign busy = state != IDLE;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         i_prev <= '0;
         timer <= '0;
         res.res_valid <= 1'b0;
         res.res_i <= '0;
         res.res_j <= '0;
         res.res_k <= '0;
         res.res_n <= '0;
         res.iter_cnt <= '0;
         res.exit_cause <= 2'b00;
         res.viol <= 1'b0;
      end else if (go) begin
         state <= RUN;
         res.res_valid <= 1'b0;
         res.iter_cnt <= '0;
         timer <= '0;
         i_prev <= i_in;
      end else begin
         case (state)
            RUN: begin
               timer <= &timer ? timer : timer + CNT_W'(1);
               if (i_in != i_prev && !(&res.iter_cnt)) res.iter_cnt <= res.iter_cnt + CNT_W'(1);
               i_prev <= i_in;
               // a timeout leaves both exit flags low, so exit_cause naturally reads 00
               if (e_i || e_j || timed_out) begin
                  res.res_i <= i_in;
                  res.res_j <= j_in;
                  res.res_k <= k_in;
                  res.res_n <= n_in;
                  res.exit_cause <= {e_j, e_i};
                  state <= EVAL;
               end
            end
            EVAL: begin
`ifdef LOOP_MON_STICKY_VIOL_EN
               res.viol <= res.viol | new_viol;
`else
               res.viol <= new_viol;
`endif
               res.res_valid <= 1'b1;
               state <= HOLD;
            end
            HOLD: if (res.res_ready) begin
               res.res_valid <= 1'b0;
               state <= IDLE;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_loop_term_monitor.sv
// tb_loop_term_monitor: randomized and directed runs checked against a sequence-level reference model.
module tb_loop_term_monitor;
   localparam int W = 13, CNT_W = 16, J_LIMIT = 4855, TIMEOUT = 4096;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [W-1:0] i_in = '0, j_in = '0, k_in = '0, n_in = '0;
   logic busy;
   int total = 0, bad = 0;
   bit viol_acc = 1'b0;
   int qi[$], qj[$], qk[$], qn[$];
   int exp_i, exp_j, exp_k, exp_n, exp_iter, exp_cause;
   bit exp_viol;
   loop_term_monitor_if #(.W(W), .CNT_W(CNT_W)) bus();
   loop_term_monitor #(.W(W), .J_LIMIT(J_LIMIT), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .start(start), .i_in(i_in), .j_in(j_in), .k_in(k_in), .n_in(n_in),
      .busy(busy), .res(bus)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic clear_q();
      qi.delete();
      qj.delete();
      qk.delete();
      qn.delete();
   endtask
   task automatic push(input int i, input int j, input int k, input int n);
      qi.push_back(i);
      qj.push_back(j);
      qk.push_back(k);
      qn.push_back(n);
   endtask
   task automatic drive(input int i, input int j, input int k, input int n);
      i_in = W'(i);
      j_in = W'(j);
      k_in = W'(k);
      n_in = W'(n);
   endtask
   task automatic drive_random();
      drive($urandom_range(0, 8191), $urandom_range(0, 8191), $urandom_range(0, 8191), $urandom_range(0, 8191));
   endtask
   task automatic check_result(input string name);
      total++;
      if (bus.res_valid !== 1'b1) begin
         bad++;
         $display("FAIL %s valid: res_valid=%0d expected 1", name, bus.res_valid);
      end
      total++;
      if (bus.res_i !== W'(exp_i) || bus.res_j !== W'(exp_j) || bus.res_k !== W'(exp_k) || bus.res_n !== W'(exp_n)) begin
         bad++;
         $display("FAIL %s res: got i=%0d j=%0d k=%0d n=%0d expected i=%0d j=%0d k=%0d n=%0d", name,
                  bus.res_i, bus.res_j, bus.res_k, bus.res_n, exp_i, exp_j, exp_k, exp_n);
      end
      total++;
      if (bus.iter_cnt !== CNT_W'(exp_iter)) begin
         bad++;
         $display("FAIL %s iter_cnt: got %0d expected %0d", name, bus.iter_cnt, exp_iter);
      end
      total++;
      if (bus.exit_cause !== 2'(exp_cause)) begin
         bad++;
         $display("FAIL %s exit_cause: got %0d expected %0d", name, bus.exit_cause, exp_cause);
      end
      total++;
      if (bus.viol !== exp_viol) begin
         bad++;
         $display("FAIL %s viol: got %0d expected %0d", name, bus.viol, exp_viol);
      end
   endtask
   // q[0] is presented with start; q[1..] are the RUN cycles
   task automatic run_check(input string name, input bit keep_hold);
      int ex = 0;
      int ei, ej;
      for (int x = 1; x < qi.size(); x++)
         if (qi[x] > qn[x] || qj[x] > J_LIMIT || x - 1 == TIMEOUT - 1) begin
            ex = x;
            break;
         end
      total++;
      if (ex == 0) begin
         bad++;
         $display("FAIL %s stimulus: exit index=%0d expected nonzero", name, ex);
         return;
      end
      exp_iter = 0;
      for (int x = 1; x <= ex; x++) if (qi[x] != qi[x-1]) exp_iter++;
      ei = qi[ex] > qn[ex] ? 1 : 0;
      ej = qj[ex] > J_LIMIT ? 1 : 0;
      exp_cause = ej * 2 + ei;
      exp_i = qi[ex];
      exp_j = qj[ex];
      exp_k = qk[ex];
      exp_n = qn[ex];
      exp_viol = ei == 1 && 2 * qn[ex] >= qi[ex] + qj[ex] + qk[ex];
`ifdef LOOP_MON_STICKY_VIOL_EN
      viol_acc = viol_acc | exp_viol;
      exp_viol = viol_acc;
`endif
      start = 1'b1;
      drive(qi[0], qj[0], qk[0], qn[0]);
      tick();
      start = 1'b0;
      for (int x = 1; x <= ex; x++) begin
         drive(qi[x], qj[x], qk[x], qn[x]);
         tick();
      end
      total++;
      if (bus.res_valid !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL %s exit+1: res_valid=%0d busy=%0d expected 0 1", name, bus.res_valid, busy);
      end
      drive_random();
      tick();
      check_result(name);
      if (!keep_hold) begin
         bus.res_ready = 1'b1;
         tick();
         bus.res_ready = 1'b0;
         total++;
         if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s accept: res_valid=%0d busy=%0d expected 0 0", name, bus.res_valid, busy);
         end
      end
   endtask
   task automatic check_zero(input string name);
      total++;
      if ({bus.res_valid, busy, bus.res_i, bus.res_j, bus.res_k, bus.res_n, bus.iter_cnt, bus.exit_cause, bus.viol} !== '0) begin
         bad++;
         $display("FAIL %s: valid=%0d busy=%0d i=%0d j=%0d k=%0d n=%0d iter=%0d cause=%0d viol=%0d expected all 0", name,
                  bus.res_valid, busy, bus.res_i, bus.res_j, bus.res_k, bus.res_n, bus.iter_cnt, bus.exit_cause, bus.viol);
      end
   endtask
   task automatic test_reset();
      bus.res_ready = 1'b0;
      #3;
      check_zero("reset");
      tick();
      rst = 1'b1;
      tick();
      check_zero("reset_release");
   endtask
   task automatic test_nominal();
      clear_q();
      for (int m = 0; m <= 100; m++) push(m, m * (m - 1) / 2, 80, 100);
      run_check("nominal", 1'b0);
   endtask
   task automatic test_i_exit();
      clear_q();
      push(0, 0, 80, 100);
      push(101, 0, 80, 100);
      run_check("i_exit_viol", 1'b0);
      clear_q();
      push(0, 0, 80, 100);
      push(101, 50, 80, 100);
      run_check("i_exit_noviol", 1'b0);
   endtask
   task automatic test_random();
      for (int r = 0; r < 10; r++) begin
         int i, j, k, n;
         n = $urandom_range(50, 400);
         k = $urandom_range(0, 300);
         i = $urandom_range(0, n);
         j = $urandom_range(0, 200);
         clear_q();
         push(i, j, k, n);
         for (int c = 0; c < 4200; c++) begin
            i = i + $urandom_range(0, 2);
            j = j + $urandom_range(0, 40);
            if (i > 8191) i = 8191;
            if (j > 8191) j = 8191;
            push(i, j, k, n);
            if (i > n || j > J_LIMIT) break;
         end
         run_check($sformatf("random%0d", r), 1'b0);
      end
   endtask
   task automatic test_timeout();
      clear_q();
      push(0, 0, 80, 100);
      push(101, 0, 80, 100);
      run_check("pre_timeout_viol", 1'b0);
      clear_q();
      for (int c = 0; c <= TIMEOUT; c++) push(5, 10, 80, 100);
      run_check("timeout", 1'b0);
   endtask
   task automatic test_backpressure();
      clear_q();
      push(0, 20, 30, 100);
      push(7, 20, 30, 100);
      push(150, 40, 30, 100);
      run_check("bp", 1'b1);
      for (int c = 0; c < 10; c++) begin
         drive_random();
         start = 1'($urandom_range(0, 1));
         tick();
         check_result($sformatf("bp_hold%0d", c));
      end
      bus.res_ready = 1'b1;
      start = 1'b1;
      drive(3, 0, 30, 100);
      tick();
      start = 1'b0;
      bus.res_ready = 1'b0;
      total++;
      if (bus.res_valid !== 1'b0 || busy !== 1'b1 || bus.iter_cnt !== '0) begin
         bad++;
         $display("FAIL bp_restart: valid=%0d busy=%0d iter=%0d expected 0 1 0", bus.res_valid, busy, bus.iter_cnt);
      end
   endtask
   task automatic test_reset_mid_run();
      for (int c = 1; c <= 5; c++) begin
         drive(3 + c, 0, 30, 100);
         tick();
      end
      total++;
      if (busy !== 1'b1 || bus.iter_cnt !== CNT_W'(5)) begin
         bad++;
         $display("FAIL mid_run: busy=%0d iter=%0d expected 1 5", busy, bus.iter_cnt);
      end
      #2;
      rst = 1'b0;
      #1;
      viol_acc = 1'b0;
      check_zero("async_reset");
      rst = 1'b1;
      drive(200, 5000, 0, 100);
      for (int c = 0; c < 5; c++) tick();
      total++;
      if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL after_reset: valid=%0d busy=%0d expected 0 0", bus.res_valid, busy);
      end
   endtask
   initial begin
      test_reset();
      test_nominal();
      test_i_exit();
      test_random();
      test_timeout();
      test_backpressure();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/loop_term_monitor.md
Name: loop_term_monitor

Overview:
- Downstream consumer of the bounded arithmetic loop block that produces counters i, j, k, n.
- Watches the loop's counter outputs every cycle and detects loop exit: i > n, or j above the limit, or a cycle timeout.
- On exit, latches the final counter values, counts iterations, and evaluates the invariant `!((i>n) && (2n >= k+j+i))`.
- Presents the result over a valid/ready handshake to a checker/scoreboard stage.

Parameters:
- W, 13, width of i/j/k/n inputs and result outputs
- J_LIMIT, 4855, loop continues while j <= J_LIMIT
- CNT_W, 16, width of iteration counter and timeout counter
- TIMEOUT, 4096, cycles in RUN without exit before a forced timeout result

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse: loop run begins, begin monitoring
- i_in  in  W  loop counter i
- j_in  in  W  loop accumulator j
- k_in  in  W  loop constant k
- n_in  in  W  loop bound n
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_i  out  W  latched final i
- res_j  out  W  latched final j
- res_k  out  W  latched final k
- res_n  out  W  latched final n
- iter_cnt  out  CNT_W  iterations observed in the run
- exit_cause  out  2  00 timeout, 01 i>n, 10 j>J_LIMIT, 11 both
- viol  out  1  invariant violated by latched values
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - All outputs 0: res_*, iter_cnt, exit_cause, viol, res_valid, busy.
  - Internal i_prev and timer cleared.
- FSM states: IDLE, RUN, EVAL, HOLD.
- IDLE:
  - start=1 → RUN; iter_cnt=0, timer=0, i_prev=i_in.
  - Otherwise stay.
- RUN, each cycle:
  - timer increments, saturating at all-ones.
  - If i_in != i_prev, iter_cnt increments, saturating at 2^CNT_W-1.
  - i_prev updates to i_in.
- RUN exit condition: e_i = (i_in > n_in), unsigned; e_j = (j_in > J_LIMIT).
  - If e_i or e_j: latch i_in/j_in/k_in/n_in into res_*, exit_cause={e_j,e_i}, → EVAL.
  - Else if timer == TIMEOUT-1: latch the same way, exit_cause=00, → EVAL.
- EVAL (one cycle):
  - lhs = {n,1'b0}, W+1 bits.
  - rhs = k+j+i, zero-extended to W+2 bits, no truncation.
  - viol = (res_i > res_n) && (lhs >= rhs).
  - → HOLD, res_valid=1 the next cycle.
- HOLD:
  - res_valid=1; res_*, iter_cnt, exit_cause, viol held stable.
  - res_valid && res_ready → res_valid=0; → IDLE.
  - If start=1 in the same cycle: → RUN directly, with the same init as from IDLE.
- Latency: exit seen at cycle t → res_valid high at t+2.
- Result hold: result outputs keep their last values in IDLE/RUN until the next latch. viol is also retained; only res_valid drops.
- start in RUN/EVAL ignored; start in HOLD without handshake ignored.
- Inputs changing after the latch have no effect on results.
- W-bit counter wrap upstream (e.g. i 8191→0) counts as an iteration (value changed). No exit unless the exit condition holds.

Optional Feature:
- Macro: LOOP_MON_STICKY_VIOL_EN.
- Defined: viol is sticky, i.e. once any EVAL sets it, it stays 1 across runs until rst asserts. EVAL ORs the new result into it.
- Undefined: viol reflects only the current latched result, overwritten each EVAL.

Test Plan:
- Nominal run: drive the loop sequence from i=0,j=0,k=80,n=100 (i=m, j=m(m-1)/2 each cycle) up to i=100,j=4950 → exit_cause=10, res_i=100, res_j=4950, iter_cnt=100, viol=0, res_valid at exit+2.
- Direct i exit: start, then i=101,j=0,k=80,n=100 → exit_cause=01; lhs 200 >= rhs 181 → viol=1.
- Non-violating i exit: i=101,j=50,k=80,n=100 → rhs 231 > 200 → viol=0, exit_cause=01.
- Backpressure: hold res_ready=0 for 10 cycles while inputs toggle → res_valid=1 and all res_* constant. Then res_ready=1 with start=1 in the same cycle → next cycle res_valid=0, busy=1, state RUN, iter_cnt=0.
- Timeout: start, hold i=5,j=10,n=100 constant → after 4096 cycles exit_cause=00, iter_cnt=0, viol=0. With the macro defined and a prior viol=1, viol stays 1.
- Reset mid-RUN: assert rst low for 1 cycle with no clock edge → outputs 0 immediately, IDLE. No result without a new start.
